control_fsm: RTL and testbench

- Multicycle successor to the single-cycle control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, with ready handshakes to instruction and data memory.
- Parametrised in opcode and ALUOp widths; adds retirement counting, halt and memory-timeout error handling.
- Sits between the instruction register/PC and the datapath (reg file, ALU, data memory).

---
 rtl/control_fsm.sv | 83 ++++++++
 tb/tb_control_fsm.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm: multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer with
// retire counting, halt request and memory-timeout error halt.
module control_fsm #(
  parameter int OPWIDTH     = 3,
  parameter int MCODEBITS   = 3,
  parameter int CNTW        = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 br_logic,
  input  logic                 halt_req,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 Done,
  output logic                 Err,
  output logic [CNTW-1:0]      retired
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nx;
  logic [MCODEBITS-1:0] op;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic is_nop, is_ldr, is_str, is_cmp, is_br, waiting, timeout, retire;
  assign is_nop  = |(op >> 3);
  assign is_ldr  = !is_nop && op[2:0] == 3'd0;
  assign is_str  = !is_nop && op[2:0] == 3'd1;
  assign is_cmp  = !is_nop && op[2:0] == 3'd6;
  assign is_br   = !is_nop && op[2:0] == 3'd7;
  assign waiting = (state == FETCH && !imem_ready) || (state == MEM && !dmem_ready);
  // ready on the limit cycle clears waiting, so it wins over the timeout
  assign timeout = waiting && wait_cnt == WW'(MEM_TIMEOUT - 1);
  assign retire  = (state == EXEC && (is_br || is_cmp || is_nop)) ||
                   (state == MEM && is_str && dmem_ready) || state == WB;
  always_comb begin
    state_nx = state;
    wait_nx  = waiting ? wait_cnt + WW'(1) : '0;
    case (state)
      FETCH:   state_nx = imem_ready ? DECODE : FETCH;
      DECODE:  state_nx = EXEC;
      EXEC:    state_nx = (is_ldr || is_str) ? MEM : retire ? FETCH : WB;
      MEM:     state_nx = !dmem_ready ? MEM : is_str ? FETCH : WB;
      WB:      state_nx = FETCH;
      default: state_nx = HALT;
    endcase
    if (timeout || (retire && halt_req)) state_nx = HALT;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= FETCH;
      op       <= '0;
      wait_cnt <= '0;
      retired  <= '0;
      Err      <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (state == DECODE) op <= instr;
      if (retire) retired <= retired + CNTW'(1);
      if (timeout) Err <= 1'b1;
    end
  end
  assign IRWrite  = state == FETCH && imem_ready;
  assign PCWrite  = retire;
  assign Branch   = state == EXEC && is_br && br_logic;
  assign MemRead  = state == MEM && is_ldr;
  assign MemWrite = state == MEM && is_str;
  assign MemtoReg = state == WB && is_ldr;
  assign ALUSrc   = 1'b0;
  assign RegWrite = state == WB;
  assign Done     = state == HALT;
  assign ALUOp    = (state inside {EXEC, MEM, WB}) && !is_nop ? OPWIDTH'(op[2:0]) : '1;
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed per-scenario checks of control_fsm with CNTW=4.
module tb_control_fsm;
  logic Clk = 0, Reset_n = 0;
  logic [2:0] instr = '0;
  logic br_logic = 0, halt_req = 0, imem_ready = 0, dmem_ready = 0;
  logic IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, Done, Err;
  logic [2:0] ALUOp;
  logic [3:0] retired;
  logic [3:0] exp_ret = '0;
  int checks = 0, fails = 0;
  logic [12:0] obs;
  assign obs = {IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, Done, Err, ALUOp};

  localparam logic [12:0] CF  = 13'b1000000000_111;
  localparam logic [12:0] CI  = 13'b0000000000_111;
  localparam logic [12:0] CH  = 13'b0000000010_111;

  control_fsm #(.OPWIDTH(3), .MCODEBITS(3), .CNTW(4), .MEM_TIMEOUT(15)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .instr(instr), .br_logic(br_logic), .halt_req(halt_req),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp), .Done(Done), .Err(Err), .retired(retired)
  );

  always #5 Clk = ~Clk;

  task automatic cycle(input logic im, input logic dm, input logic [2:0] ins, input logic br, input logic hr);
    @(negedge Clk);
    imem_ready = im; dmem_ready = dm; instr = ins; br_logic = br; halt_req = hr;
    #1;
  endtask

  task automatic test_reset;
    Reset_n = 0;
    @(negedge Clk); #1;
    checks++; if (obs !== CI) begin fails++; $display("FAIL reset_ctl: got %b expected %b", obs, CI); end
    checks++; if (retired !== 4'd0) begin fails++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    @(negedge Clk);
    Reset_n = 1;
  endtask

  task automatic test_mov;
    logic [12:0] e [4] = '{CF, CI, 13'b0000000000_010, 13'b0100000100_010};
    for (int i = 0; i < 4; i++) begin
      cycle(i == 0, 0, 3'b010, 0, 0);
      if (i == 0) begin
        checks++; if (retired !== exp_ret) begin fails++; $display("FAIL mov_ret_start: got %0d expected %0d", retired, exp_ret); end
      end
      checks++; if (obs !== e[i]) begin fails++; $display("FAIL mov c%0d: got %b expected %b", i, obs, e[i]); end
    end
    exp_ret++;
  endtask

  task automatic test_fetch_boundary;
    for (int i = 0; i < 15; i++) begin
      cycle(i == 14, 0, 3'b110, 0, 0);
      if (i == 0) begin
        checks++; if (retired !== exp_ret) begin fails++; $display("FAIL bnd_ret_start: got %0d expected %0d", retired, exp_ret); end
      end
      checks++; if ({IRWrite, Done} !== {i == 14, 1'b0}) begin fails++; $display("FAIL bnd_wait c%0d: got %b expected %b", i, {IRWrite, Done}, {i == 14, 1'b0}); end
    end
    cycle(0, 0, 3'b110, 0, 0);
    cycle(0, 0, 3'b110, 0, 0);
    checks++; if (obs !== 13'b0100000000_110) begin fails++; $display("FAIL bnd_cmp_exec: got %b expected %b", obs, 13'b0100000000_110); end
    exp_ret++;
  endtask

  task automatic test_ldr;
    logic [12:0] e [8] = '{CF, CI, 13'b0000000000_000, 13'b0001000000_000, 13'b0001000000_000,
                           13'b0001000000_000, 13'b0001000000_000, 13'b0100010100_000};
    for (int i = 0; i < 8; i++) begin
      cycle(i == 0, i == 6, 3'b000, 0, 0);
      if (i == 0) begin
        checks++; if (retired !== exp_ret) begin fails++; $display("FAIL ldr_ret_start: got %0d expected %0d", retired, exp_ret); end
      end
      checks++; if (obs !== e[i]) begin fails++; $display("FAIL ldr c%0d: got %b expected %b", i, obs, e[i]); end
    end
    exp_ret++;
  endtask

  task automatic test_branch;
    logic [12:0] e [6] = '{CF, CI, 13'b0110000000_111, CF, CI, 13'b0100000000_111};
    for (int i = 0; i < 6; i++) begin
      cycle(i == 0 || i == 3, 0, 3'b111, i < 3, 0);
      if (i == 0 || i == 3) begin
        checks++; if (retired !== exp_ret) begin fails++; $display("FAIL br_ret c%0d: got %0d expected %0d", i, retired, exp_ret); end
      end
      checks++; if (obs !== e[i]) begin fails++; $display("FAIL br c%0d: got %b expected %b", i, obs, e[i]); end
      if (i == 2) exp_ret++;
    end
    exp_ret++;
  endtask

  task automatic test_halt;
    logic [12:0] e [7] = '{CF, CI, 13'b0000000000_001, 13'b0100100000_001, CH, CH, CH};
    for (int i = 0; i < 7; i++) begin
      cycle(i == 0 || i >= 5, i == 3, 3'b001, 0, i <= 3);
      if (i == 0 || i == 4) begin
        checks++; if (retired !== exp_ret) begin fails++; $display("FAIL halt_ret c%0d: got %0d expected %0d", i, retired, exp_ret); end
      end
      checks++; if (obs !== e[i]) begin fails++; $display("FAIL halt c%0d: got %b expected %b", i, obs, e[i]); end
      if (i == 3) exp_ret++;
    end
  endtask

  task automatic test_timeout;
    @(negedge Clk); Reset_n = 0; imem_ready = 0; dmem_ready = 0; halt_req = 0;
    @(negedge Clk); Reset_n = 1;
    exp_ret = '0;
    for (int i = 0; i < 19; i++) begin
      logic [12:0] ex;
      cycle(i == 0, 0, 3'b000, 0, 0);
      ex = i == 0 ? CF : i == 1 ? CI : i == 2 ? 13'b0000000000_000 : i < 18 ? 13'b0001000000_000 : 13'b0000000011_111;
      checks++; if (obs !== ex) begin fails++; $display("FAIL timeout c%0d: got %b expected %b", i, obs, ex); end
    end
    checks++; if (retired !== exp_ret) begin fails++; $display("FAIL timeout_ret: got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_mid_reset;
    @(negedge Clk); Reset_n = 0;
    @(negedge Clk); Reset_n = 1;
    for (int i = 0; i < 3; i++) cycle(i == 0, 0, 3'b110, 0, 0);
    for (int i = 0; i < 4; i++) cycle(i == 0, 0, 3'b001, 0, 0);
    checks++; if (obs !== 13'b0000100000_001 || retired !== 4'd1) begin fails++; $display("FAIL midrst_mem: got %b/%0d expected %b/1", obs, retired, 13'b0000100000_001); end
    #2 Reset_n = 0;
    #1;
    checks++; if (obs !== CI || retired !== 4'd0) begin fails++; $display("FAIL midrst_async: got %b/%0d expected %b/0", obs, retired, CI); end
    @(negedge Clk); Reset_n = 1;
    cycle(0, 1, 3'b001, 0, 0);
    checks++; if (obs !== CI || retired !== 4'd0) begin fails++; $display("FAIL midrst_release: got %b/%0d expected %b/0", obs, retired, CI); end
    exp_ret = '0;
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 17; k++) begin
      cycle(1, 0, 3'b110, 0, 0);
      if (k == 15 || k == 16) begin
        checks++; if (retired !== exp_ret) begin fails++; $display("FAIL wrap k%0d: got %0d expected %0d", k, retired, exp_ret); end
      end
      cycle(0, 0, 3'b110, 0, 0);
      cycle(0, 0, 3'b110, 0, 0);
      exp_ret++;
    end
    cycle(0, 0, 3'b000, 0, 0);
    checks++; if (retired !== 4'd1) begin fails++; $display("FAIL wrap_final: got %0d expected 1", retired); end
  endtask

  initial begin
    test_reset;
    test_mov;
    test_fetch_boundary;
    test_ldr;
    test_branch;
    test_halt;
    test_timeout;
    test_mid_reset;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
